// File: rtl/fifo_rd_master_if.sv
// FIFO read port plus output stream bundle for fifo_rd_master.
// master = the read master (pops the FIFO, sources the stream).
interface fifo_rd_master_if #(
  parameter int DATAWIDTH = 8
);
  logic                 fifo_empty;
  logic                 fifo_rd;
  logic [DATAWIDTH-1:0] fifo_dout;
  logic                 m_valid;
  logic [DATAWIDTH-1:0] m_data;
  logic                 m_ready;

  modport master (
    input  fifo_empty, fifo_dout, m_ready,
    output fifo_rd, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_dout, m_ready,
    input  fifo_rd, m_valid, m_data
  );
endinterface

// File: rtl/fifo_rd_master.sv
// Pulls words from a synchronous FIFO (1-cycle read latency) and presents
// them as a valid/ready stream through a 2-entry skid buffer.
// Every issued read always has a free buffer slot waiting for it, so the
// buffer cannot overflow.
module fifo_rd_master #(
  parameter int DATAWIDTH = 8,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_enable,
  fifo_rd_master_if.master     bus,
  output logic                 o_busy,
  output logic [CNT_W-1:0]     o_rd_count
);

  logic [1:0]           r_occ;
  logic                 r_inflight;
  logic                 r_head;
  logic                 r_tail;
  logic [DATAWIDTH-1:0] r_buf [2];
  logic [CNT_W-1:0]     r_count;

  logic                 w_pop;
  logic [2:0]           w_level;
  logic                 w_rd;

  // Slots committed after this edge: buffered + in flight - leaving now.
  // pop implies occ >= 1, so this never underflows.
  always_comb begin
    w_pop   = bus.m_valid & bus.m_ready;
    w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    w_rd    = ~reset & i_enable & ~bus.fifo_empty & (w_level < 3'd2);
  end

  assign bus.fifo_rd = w_rd;
  assign bus.m_valid = (r_occ != 2'd0);
  assign bus.m_data  = r_buf[r_head];
  assign o_busy      = (r_occ != 2'd0) | r_inflight;
  assign o_rd_count  = r_count;

  // Buffer pointers, occupancy, in-flight flag and transfer counter.
  // Reset drops everything, including a read data word arriving now.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_count    <= '0;
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
    end else begin
      r_inflight <= w_rd;
      if (r_inflight) begin
        r_buf[r_tail] <= bus.fifo_dout;
        r_tail        <= ~r_tail;
      end
      if (w_pop) begin
        r_head  <= ~r_head;
        r_count <= r_count + CNT_W'(1);
      end
      r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_fifo_rd_master.sv
// Directed bench for fifo_rd_master: behavioural FIFO with registered read
// data, scoreboard of pushed words popped on every stream transfer.
module tb_fifo_rd_master;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          busy;
  logic [CW-1:0] rd_count;

  fifo_rd_master_if #(.DATAWIDTH(DW)) bus ();

  fifo_rd_master #(.DATAWIDTH(DW), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_enable   (enable),
    .bus        (bus),
    .o_busy     (busy),
    .o_rd_count (rd_count)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:255];
  int            wp = 0;
  int            rp = 0;
  logic [DW-1:0] exp_q [$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rd_pulses = 0;
  int   first_pop = -1;
  int   last_pop = -1;
  logic last_rd = 1'b0;

  assign bus.fifo_empty = (wp == rp);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] v);
    mem[wp[7:0]] = v;
    wp++;
    exp_q.push_back(v);
  endtask

  // One clock: sample at negedge, advance FIFO model just after posedge.
  task automatic step();
    logic [31:0] e;
    @(negedge clk);
    last_rd = bus.fifo_rd;
    if (bus.fifo_rd) begin
      rd_pulses++;
      chk("rd_when_empty", {31'd0, bus.fifo_empty}, 32'd0);
    end
    if (bus.m_valid && bus.m_ready) begin
      e = (exp_q.size() != 0) ? {24'd0, exp_q.pop_front()} : 32'hDEAD;
      chk("sb_data", {24'd0, bus.m_data}, e);
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (last_rd) begin
      bus.fifo_dout = mem[rp[7:0]];
      rp++;
    end
  endtask

  task automatic flush();
    rp = wp;
    exp_q.delete();
    rd_pulses = 0;
    first_pop = -1;
    last_pop = -1;
    bus.fifo_dout = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    flush();
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    bus.m_ready = 1'b0;
    bus.fifo_dout = '0;

    // reset with a non-empty FIFO: no reads, all outputs cleared
    push(8'h33);
    step();
    step();
    chk("rst_no_rd", rd_pulses, 0);
    chk("rst_valid", {31'd0, bus.m_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_count", {28'd0, rd_count}, 0);
    chk("rst_data", {24'd0, bus.m_data}, 0);
    reset = 1'b0;
    flush();
    step();

    // single word latency
    bus.m_ready = 1'b1;
    push(8'h5A);
    step();
    chk("single_rd_N", {31'd0, last_rd}, 1);
    chk("single_valid_N1", {31'd0, bus.m_valid}, 0);
    chk("single_busy_N1", {31'd0, busy}, 1);
    step();
    chk("single_valid_N2", {31'd0, bus.m_valid}, 1);
    chk("single_data_N2", {24'd0, bus.m_data}, 32'h5A);
    step();
    chk("single_count", {28'd0, rd_count}, 1);
    chk("single_busy_end", {31'd0, busy}, 0);
    chk("single_pulses", rd_pulses, 1);

    // stream 1..8 at full rate
    do_reset();
    bus.m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    for (int k = 0; k < 14; k++) step();
    chk("stream_pulses", rd_pulses, 8);
    chk("stream_count", {28'd0, rd_count}, 8);
    chk("stream_left", exp_q.size(), 0);
    chk("stream_back2back", last_pop - first_pop, 7);

    // backpressure
    do_reset();
    bus.m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push(DW'(i));
    for (int k = 0; k < 6; k++) step();
    chk("bp_pulses", rd_pulses, 2);
    chk("bp_valid", {31'd0, bus.m_valid}, 1);
    chk("bp_hold_data", {24'd0, bus.m_data}, 1);
    bus.m_ready = 1'b1;
    for (int k = 0; k < 12; k++) step();
    chk("bp_left", exp_q.size(), 0);
    chk("bp_count", {28'd0, rd_count}, 5);
    chk("bp_pulses_all", rd_pulses, 5);

    // enable drop after third read, then resume
    do_reset();
    bus.m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    for (int k = 0; k < 20 && rd_pulses < 3; k++) step();
    enable = 1'b0;
    chk("en_pulses_at_drop", rd_pulses, 3);
    for (int k = 0; k < 6; k++) step();
    chk("en_count_held", {28'd0, rd_count}, 3);
    chk("en_fifo_kept", wp - rp, 5);
    chk("en_busy_idle", {31'd0, busy}, 0);
    enable = 1'b1;
    for (int k = 0; k < 12; k++) step();
    chk("en_count_all", {28'd0, rd_count}, 8);
    chk("en_left", exp_q.size(), 0);

    // reset mid-stream with a full buffer
    do_reset();
    bus.m_ready = 1'b1;
    for (int i = 1; i <= 5; i++) push(DW'(i));
    for (int k = 0; k < 4; k++) step();
    chk("mid_count_pre", {28'd0, rd_count}, 2);
    bus.m_ready = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("mid_valid_pre", {31'd0, bus.m_valid}, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_valid_post", {31'd0, bus.m_valid}, 0);
    chk("mid_count_post", {28'd0, rd_count}, 0);
    chk("mid_busy_post", {31'd0, busy}, 0);
    flush();
    bus.m_ready = 1'b1;
    push(8'hA1);
    push(8'hA2);
    for (int k = 0; k < 8; k++) step();
    chk("mid_new_left", exp_q.size(), 0);
    chk("mid_new_count", {28'd0, rd_count}, 2);

    // counter wrap at 4 bits
    do_reset();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 17; i++) push(DW'(8'h40 + i));
    for (int k = 0; k < 24; k++) step();
    chk("wrap_left", exp_q.size(), 0);
    chk("wrap_count", {28'd0, rd_count}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_master.md
FIFO_RD_MASTER -- requirements
Module: fifo_rd_master

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, width of FIFO read data and output stream data.
REQ-002 SHALL have parameter CNT_W, default 16, width of delivered-word counter.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  permits new FIFO reads when high.
REQ-006 fifo_empty  input  1  empty flag from synchronous FIFO read port.
REQ-007 fifo_rd  output  1  read strobe to FIFO; one word popped per cycle asserted.
REQ-008 fifo_dout  input  DATAWIDTH  FIFO registered read data; valid the cycle after fifo_rd high.
REQ-009 m_valid  output  1  output stream word valid.
REQ-010 m_data  output  DATAWIDTH  output stream word.
REQ-011 m_ready  input  1  downstream accepts word; transfer = m_valid && m_ready at rising edge.
REQ-012 busy  output  1  high while any word is in flight or buffered.
REQ-013 rd_count  output  CNT_W  count of completed output transfers since reset.

Function
REQ-014 SHALL hold a 2-entry output buffer (occ 0..2) plus a 1-bit in-flight flag (read issued, data not yet captured).
REQ-015 SHALL compute pop = m_valid && m_ready, combinationally.
REQ-016 SHALL assert fifo_rd = enable && !fifo_empty && (occ + inflight - pop) < 2; combinational path m_ready -> fifo_rd is permitted.
REQ-017 SHALL never assert fifo_rd while fifo_empty is high, including in the cycle reset deasserts.
REQ-018 SHALL set inflight at each edge to the value of fifo_rd in the preceding cycle.
REQ-019 SHALL, in the cycle inflight is high, capture fifo_dout into the buffer tail at the rising edge ending that cycle.
REQ-020 SHALL drive m_valid = (occ != 0), from registered state only.
REQ-021 SHALL drive m_data from the buffer head; head SHALL hold stable while m_valid && !m_ready.
REQ-022 SHALL deliver words in exact FIFO pop order, no drop, no duplication.
REQ-023 Simultaneous capture and pop: occ unchanged, head advances, new word enters tail.
REQ-024 Latency: fifo_empty falls in cycle N with enable high and buffer empty -> fifo_rd high in N, m_valid high in N+2.
REQ-025 Throughput: with m_ready held high and FIFO non-empty, SHALL sustain one transfer per cycle after initial latency.
REQ-026 Backpressure: with m_ready low, SHALL stop issuing reads once occ + inflight = 2; no overflow.
REQ-027 enable low SHALL block new reads only; in-flight and buffered words SHALL still be captured and delivered.
REQ-028 busy SHALL equal (occ != 0) || inflight.
REQ-029 rd_count SHALL increment by 1 on each pop, modulo 2^CNT_W (all-ones wraps to 0).
REQ-030 Buffer overflow (capture with occ=2 and no pop) SHALL be unreachable under REQ-016.

Reset
REQ-031 On reset: occ=0, inflight=0, head/tail pointers 0, rd_count=0, m_data=0, m_valid=0, fifo_rd=0, busy=0.
REQ-032 Reset mid-operation SHALL discard buffered and in-flight words; a FIFO word popped in the reset cycle is lost, not delivered.
REQ-033 fifo_rd SHALL be 0 in every cycle reset is high.

Verification
REQ-034 Single word: FIFO holds 0x5A, enable=1, m_ready=1 -> one fifo_rd pulse, m_valid 2 cycles later with m_data=0x5A, rd_count=1, busy falls next cycle.
REQ-035 Stream: FIFO holds 1..8, m_ready=1 -> 8 consecutive transfers, data 1..8 in order, exactly 8 fifo_rd cycles, rd_count=8.
REQ-036 Backpressure: FIFO holds 1..5, m_ready=0 -> exactly 2 fifo_rd pulses, m_data=1 held; release m_ready -> 1..5 delivered in order.
REQ-037 Enable drop: stream of 1..8, enable low after 3rd fifo_rd -> words 1..3 delivered, FIFO retains 4..8; enable high -> 4..8 follow.
REQ-038 Reset mid-stream: reset asserted with occ=2 -> next cycle m_valid=0, rd_count=0, busy=0; no stale word appears afterward.
REQ-039 Counter wrap: CNT_W=4, 17 transfers -> rd_count reads 1.
